// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - transmit byte FIFO feeding the uart_tx serializer one start pulse per byte
module uart_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int AW           = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          clr_ovf,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  input  logic          tx_busy
);

  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] TO_LAST  = CW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   to_cnt_q, to_cnt_d;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [7:0]      mem [DEPTH];
  logic            push_ok;
  logic            push_drop;
  logic            pop;

  // Status flags decode only registered level, so bus-side logic sees no comb path.
  assign full      = (level == FULL_LVL);
  assign empty     = (level == '0);
  assign push_ok   = wr_en && !full;
  assign push_drop = wr_en && full;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // A dropped push outranks a same-cycle clear so no loss goes unreported.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (push_drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      to_cnt_q <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      tx_start <= pop;
      if (pop) begin
        tx_data <= mem[rd_ptr];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (!empty && !tx_busy) begin
          pop     = 1'b1;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        // A serializer that never acknowledges must not stall the queue forever.
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clr_ovf;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;

  int checks = 0;
  int errors = 0;

  // Serializer model: 0 = busy forced low, 1 = busy forced high, 2 = frame model.
  int       mode = 0;
  int       frame_len = 3;
  int       busy_cnt = 0;
  bit       pend = 0;
  bit       prev_start = 0;
  bit       dbl_start = 0;
  logic [7:0] cap[$];

  uart_tx_fifo #(.DEPTH(16), .AW(4), .BUSY_TIMEOUT(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .clr_ovf  (clr_ovf),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (tx_start) cap.push_back(tx_data);
    if (tx_start && prev_start) dbl_start = 1;
    prev_start = tx_start;
    if (mode == 2) begin
      if (pend) begin
        busy_cnt = frame_len;
        pend = 0;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      tx_busy = (busy_cnt > 0);
      if (tx_start) pend = 1;
    end
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_cap(input int n, input int budget, input string tag);
    int cyc = 0;
    while (cap.size() < n && cyc < budget) begin
      tick();
      cyc++;
    end
    chk(tag, 32'(cap.size() >= n), 32'd1);
  endtask

  task automatic set_mode(input int m, input int flen);
    mode = m;
    frame_len = flen;
    busy_cnt = 0;
    pend = 0;
    tx_busy = (m == 1);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; clr_ovf = 1'b0; tx_busy = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_level", 32'(level), 32'd0);

    // T1: single byte, start pulse two cycles after push
    set_mode(2, 3);
    cap.delete();
    push(8'h55);
    chk("t1_level_after_push", 32'(level), 32'd1);
    chk("t1_no_start_yet", 32'(tx_start), 32'd0);
    tick();
    chk("t1_start", 32'(tx_start), 32'd1);
    chk("t1_data", 32'(tx_data), 32'h55);
    repeat (10) tick();
    chk("t1_pulse_count", 32'(cap.size()), 32'd1);
    chk("t1_level_end", 32'(level), 32'd0);
    chk("t1_empty_end", 32'(empty), 32'd1);

    // T2: fill with drain held off, then overflow
    set_mode(1, 0);
    for (int i = 1; i <= 16; i++) push(8'(i));
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_level16", 32'(level), 32'd16);
    chk("t2_no_ovf_yet", 32'(overflow), 32'd0);
    push(8'hAA);
    chk("t2_overflow", 32'(overflow), 32'd1);
    chk("t2_level_stays", 32'(level), 32'd16);

    // T3: drain with 10-cycle frames
    cap.delete();
    set_mode(2, 10);
    wait_cap(16, 1000, "t3_drain_timeout");
    repeat (20) tick();
    chk("t3_count", 32'(cap.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < cap.size()) chk($sformatf("t3_byte%0d", i), 32'(cap[i]), 32'(i + 1));
    end
    chk("t3_level_end", 32'(level), 32'd0);
    chk("t3_ovf_sticky", 32'(overflow), 32'd1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("t3_ovf_cleared", 32'(overflow), 32'd0);

    // T4: push and pop in the same cycle on a full FIFO
    set_mode(1, 0);
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
    chk("t4_full", 32'(full), 32'd1);
    cap.delete();
    set_mode(2, 2);
    wr_en = 1'b1; wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    chk("t4_level15", 32'(level), 32'd15);
    chk("t4_overflow", 32'(overflow), 32'd1);
    chk("t4_start", 32'(tx_start), 32'd1);
    chk("t4_data", 32'(tx_data), 32'h80);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("t4_ovf_cleared", 32'(overflow), 32'd0);
    wait_cap(16, 1000, "t4_drain_timeout");
    repeat (10) tick();
    chk("t4_count", 32'(cap.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < cap.size()) chk($sformatf("t4_byte%0d", i), 32'(cap[i]), 32'h80 + 32'(i));
    end

    // T5: busy never rises, timeout returns to IDLE without resend
    set_mode(0, 0);
    cap.delete();
    push(8'h33);
    tick();
    chk("t5_start", 32'(tx_start), 32'd1);
    chk("t5_data", 32'(tx_data), 32'h33);
    repeat (3) tick();
    chk("t5_still_wait_busy", 32'(dut.state_q), 32'd1);
    tick();
    chk("t5_back_idle", 32'(dut.state_q), 32'd0);
    repeat (10) tick();
    chk("t5_one_pulse", 32'(cap.size()), 32'd1);
    chk("t5_empty", 32'(empty), 32'd1);

    // T6: reset mid-frame with bytes queued
    set_mode(2, 20);
    for (int i = 0; i < 6; i++) push(8'h61 + 8'(i));
    chk("t6_level5", 32'(level), 32'd5);
    chk("t6_wait_done", 32'(dut.state_q), 32'd2);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("t6_level0", 32'(level), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_tx_start", 32'(tx_start), 32'd0);
    chk("t6_idle", 32'(dut.state_q), 32'd0);
    chk("t6_tx_data", 32'(tx_data), 32'h0);
    cap.delete();
    push(8'h77);
    push(8'h78);
    wait_cap(2, 500, "t6_drain_timeout");
    repeat (5) tick();
    chk("t6_count", 32'(cap.size()), 32'd2);
    if (cap.size() >= 2) begin
      chk("t6_byte0", 32'(cap[0]), 32'h77);
      chk("t6_byte1", 32'(cap[1]), 32'h78);
    end

    chk("no_back_to_back_start", 32'(dbl_start), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
